// File: rtl/directory_controller.sv
// Two-cache directory controller: arbitrates requests, consults an external
// next-state block, snoops the other cache when its state changes, replies.
// Ports: clk, rst (sync, high); c1_/c2_req_* request ports; ns_* next-state
// lookup; snp_* snoop to the other cache; rsp_* reply to the requester.
module directory_controller #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c1_req_valid,
  output logic             c1_req_ready,
  input  logic [2:0]       c1_req_op,
  input  logic [IDX_W-1:0] c1_req_idx,
  input  logic             c2_req_valid,
  output logic             c2_req_ready,
  input  logic [2:0]       c2_req_op,
  input  logic [IDX_W-1:0] c2_req_idx,
  output logic [3:0]       ns_state,
  output logic [2:0]       ns_op,
  output logic [1:0]       ns_src,
  output logic [1:0]       ns_dest,
  input  logic [3:0]       ns_next,
  output logic             snp_valid,
  output logic [1:0]       snp_dest,
  output logic [2:0]       snp_op,
  output logic [IDX_W-1:0] snp_idx,
  input  logic             snp_ack,
  output logic             rsp_valid,
  output logic [1:0]       rsp_dest,
  output logic [2:0]       rsp_op,
  output logic [IDX_W-1:0] rsp_idx,
  input  logic             rsp_ready
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [2:0] OP_REPLY = 3'd2;
  localparam logic [2:0] OP_RD    = 3'd3;
  localparam logic [2:0] OP_INV   = 3'd5;

  typedef enum logic [1:0] {IDLE, LOOKUP, SNOOP, RESP} state_t;

  state_t           state_q;
  logic [3:0]       dir_q [DEPTH];
  logic [2:0]       op_q;
  logic [2:0]       snp_op_q;
  logic [IDX_W-1:0] idx_q;
  logic             src2_q;
  logic             last2_q;

  logic       gnt1, gnt2;
  logic [3:0] cur;
  logic [1:0] cur_oth, nxt_oth;
  logic       skip;
  logic [1:0] src_id, oth_id;

  // Contested cycle goes to the port not served last.
  assign gnt1 = c1_req_valid & (~c2_req_valid | last2_q);
  assign gnt2 = c2_req_valid & (~c1_req_valid | ~last2_q);

  assign c1_req_ready = (state_q == IDLE) & ~rst & gnt1;
  assign c2_req_ready = (state_q == IDLE) & ~rst & gnt2;

  assign cur     = dir_q[idx_q];
  assign cur_oth = src2_q ? cur[1:0] : cur[3:2];
  assign nxt_oth = src2_q ? ns_next[1:0] : ns_next[3:2];
  assign skip    = (op_q == 3'd0) | (op_q == 3'd1) | (op_q == OP_REPLY);
  assign src_id  = src2_q ? 2'd2 : 2'd1;
  assign oth_id  = src2_q ? 2'd1 : 2'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last2_q  <= 1'b1;
      op_q     <= '0;
      snp_op_q <= '0;
      idx_q    <= '0;
      src2_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) dir_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c1_req_ready) begin
            op_q    <= c1_req_op;
            idx_q   <= c1_req_idx;
            src2_q  <= 1'b0;
            last2_q <= 1'b0;
            state_q <= LOOKUP;
          end else if (c2_req_ready) begin
            op_q    <= c2_req_op;
            idx_q   <= c2_req_idx;
            src2_q  <= 1'b1;
            last2_q <= 1'b1;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (skip) begin
            state_q <= IDLE;
          end else begin
            dir_q[idx_q] <= ns_next;
            if (nxt_oth != cur_oth) begin
              // Other cache keeps a shared copy -> RD, otherwise invalidate.
              snp_op_q <= (nxt_oth == 2'd1) ? OP_RD : OP_INV;
              state_q  <= SNOOP;
            end else begin
              state_q <= RESP;
            end
          end
        end
        SNOOP: if (snp_ack) state_q <= RESP;
        RESP:  if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ns_state  = '0;
    ns_op     = '0;
    ns_src    = '0;
    ns_dest   = '0;
    snp_valid = 1'b0;
    snp_dest  = '0;
    snp_op    = '0;
    snp_idx   = '0;
    rsp_valid = 1'b0;
    rsp_dest  = '0;
    rsp_op    = '0;
    rsp_idx   = '0;
    case (state_q)
      LOOKUP: begin
        ns_state = cur;
        ns_op    = op_q;
        ns_src   = src_id;
        ns_dest  = oth_id;
      end
      SNOOP: begin
        snp_valid = 1'b1;
        snp_dest  = oth_id;
        snp_op    = snp_op_q;
        snp_idx   = idx_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_dest  = src_id;
        rsp_op    = OP_REPLY;
        rsp_idx   = idx_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_directory_controller.sv
// Directed bench for directory_controller with a small MSI next-state model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_directory_controller;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             c1_req_valid, c1_req_ready;
  logic [2:0]       c1_req_op;
  logic [IDX_W-1:0] c1_req_idx;
  logic             c2_req_valid, c2_req_ready;
  logic [2:0]       c2_req_op;
  logic [IDX_W-1:0] c2_req_idx;
  logic [3:0]       ns_state;
  logic [2:0]       ns_op;
  logic [1:0]       ns_src, ns_dest;
  logic [3:0]       ns_next;
  logic             snp_valid;
  logic [1:0]       snp_dest;
  logic [2:0]       snp_op;
  logic [IDX_W-1:0] snp_idx;
  logic             snp_ack;
  logic             rsp_valid;
  logic [1:0]       rsp_dest;
  logic [2:0]       rsp_op;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  directory_controller #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready),
    .c1_req_op(c1_req_op), .c1_req_idx(c1_req_idx),
    .c2_req_valid(c2_req_valid), .c2_req_ready(c2_req_ready),
    .c2_req_op(c2_req_op), .c2_req_idx(c2_req_idx),
    .ns_state(ns_state), .ns_op(ns_op), .ns_src(ns_src),
    .ns_dest(ns_dest), .ns_next(ns_next),
    .snp_valid(snp_valid), .snp_dest(snp_dest), .snp_op(snp_op),
    .snp_idx(snp_idx), .snp_ack(snp_ack),
    .rsp_valid(rsp_valid), .rsp_dest(rsp_dest), .rsp_op(rsp_op),
    .rsp_idx(rsp_idx), .rsp_ready(rsp_ready)
  );

  // MSI next-state model; ops that must never be written return 4'hF.
  function automatic logic [3:0] nxt(input logic [3:0] st,
                                     input logic [2:0] op,
                                     input logic [1:0] src);
    logic [1:0] rq, ot;
    rq = (src == 2'd2) ? st[3:2] : st[1:0];
    ot = (src == 2'd2) ? st[1:0] : st[3:2];
    case (op)
      3'd3: begin
        if (rq != 2'd2) rq = 2'd1;
        if (ot == 2'd2) ot = 2'd1;
      end
      3'd4, 3'd7: begin rq = 2'd2; ot = 2'd0; end
      3'd5: ot = 2'd0;
      3'd6: rq = 2'd2;
      default: return 4'hf;
    endcase
    return (src == 2'd2) ? {rq, ot} : {ot, rq};
  endfunction

  assign ns_next = nxt(ns_state, ns_op, ns_src);

  // Drives a request from the current falling edge until accepted (bounded);
  // returns at the falling edge of the cycle after the handshake.
  task automatic issue(input int port, input logic [2:0] op,
                       input logic [IDX_W-1:0] idx,
                       output logic got, output int waits);
    got = 1'b0;
    waits = 0;
    if (port == 1) begin
      c1_req_valid = 1'b1; c1_req_op = op; c1_req_idx = idx;
    end else begin
      c2_req_valid = 1'b1; c2_req_op = op; c2_req_idx = idx;
    end
    while (!got && waits < 20) begin
      #1;
      got = (port == 1) ? c1_req_ready : c2_req_ready;
      if (!got) waits++;
      @(negedge clk);
    end
    if (port == 1) c1_req_valid = 1'b0;
    else c2_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c1_req_valid = 0; c1_req_op = 0; c1_req_idx = 0;
    c2_req_valid = 0; c2_req_op = 0; c2_req_idx = 0;
    snp_ack = 0; rsp_ready = 1;
    do_reset();
    #1;
    tests++;
    if ({c1_req_ready, c2_req_ready, snp_valid, rsp_valid} !== 4'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=0000",
               {c1_req_ready, c2_req_ready, snp_valid, rsp_valid});
    end
    tests++;
    if ({ns_state, ns_op, ns_src, ns_dest} !== 11'd0) begin
      fails++;
      $display("FAIL reset_ns got=%h want=0",
               {ns_state, ns_op, ns_src, ns_dest});
    end
  endtask

  task automatic test_rd_basic();
    logic got; int w;
    @(negedge clk);
    issue(1, 3'd3, 6'd5, got, w);
    #1;
    tests++;
    if (!got || w != 0) begin
      fails++; $display("FAIL rd_ready got=%0b waits=%0d want 1/0", got, w);
    end
    tests++;
    if ({ns_state, ns_op, ns_src, ns_dest} !== {4'd0, 3'd3, 2'd1, 2'd2}) begin
      fails++;
      $display("FAIL rd_lookup st=%h op=%0d src=%0d dst=%0d want 0/3/1/2",
               ns_state, ns_op, ns_src, ns_dest);
    end
    @(negedge clk); #1;
    tests++;
    if ({rsp_valid, rsp_dest, rsp_op, rsp_idx, snp_valid} !==
        {1'b1, 2'd1, 3'd2, 6'd5, 1'b0}) begin
      fails++;
      $display("FAIL rd_resp v=%b d=%0d op=%0d idx=%0d snp=%b want 1/1/2/5/0",
               rsp_valid, rsp_dest, rsp_op, rsp_idx, snp_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rd_done rsp_valid=%b want 0", rsp_valid);
    end
    // Second reader sees c1 shared in entry 5; no snoop needed.
    issue(2, 3'd3, 6'd5, got, w);
    #1;
    tests++;
    if (!got || ns_state !== 4'b0001 || ns_src !== 2'd2) begin
      fails++;
      $display("FAIL rd_entry5 got=%b st=%b src=%0d want 1/0001/2",
               got, ns_state, ns_src);
    end
    @(negedge clk); #1;
    tests++;
    if ({rsp_valid, rsp_dest, snp_valid} !== {1'b1, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL rd2_resp v=%b d=%0d snp=%b want 1/2/0",
               rsp_valid, rsp_dest, snp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_snoop();
    logic got; int w;
    issue(1, 3'd3, 6'd9, got, w);
    @(negedge clk);
    @(negedge clk);
    issue(2, 3'd7, 6'd9, got, w);
    #1;
    tests++;
    if (!got || ns_state !== 4'b0001) begin
      fails++; $display("FAIL snp_lookup got=%b st=%b want 1/0001", got, ns_state);
    end
    @(negedge clk); #1;
    tests++;
    if ({snp_valid, snp_dest, snp_op, snp_idx, rsp_valid} !==
        {1'b1, 2'd1, 3'd5, 6'd9, 1'b0}) begin
      fails++;
      $display("FAIL snp_issue v=%b d=%0d op=%0d idx=%0d rsp=%b want 1/1/5/9/0",
               snp_valid, snp_dest, snp_op, snp_idx, rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    tests++;
    if ({snp_valid, snp_dest, snp_op, snp_idx} !== {1'b1, 2'd1, 3'd5, 6'd9}) begin
      fails++;
      $display("FAIL snp_hold v=%b d=%0d op=%0d idx=%0d want 1/1/5/9",
               snp_valid, snp_dest, snp_op, snp_idx);
    end
    snp_ack = 1'b1;
    @(negedge clk);
    snp_ack = 1'b0;
    #1;
    tests++;
    if ({rsp_valid, rsp_dest, rsp_idx, snp_valid} !==
        {1'b1, 2'd2, 6'd9, 1'b0}) begin
      fails++;
      $display("FAIL snp_resp v=%b d=%0d idx=%0d snp=%b want 1/2/9/0",
               rsp_valid, rsp_dest, rsp_idx, snp_valid);
    end
    @(negedge clk);
    // c1 re-reads: entry must be c2 M, and c2 gets downgraded via RD snoop.
    issue(1, 3'd3, 6'd9, got, w);
    #1;
    tests++;
    if (ns_state !== 4'b1000) begin
      fails++; $display("FAIL snp_entry9 got=%b want 1000", ns_state);
    end
    @(negedge clk); #1;
    tests++;
    if ({snp_valid, snp_dest, snp_op} !== {1'b1, 2'd2, 3'd3}) begin
      fails++;
      $display("FAIL snp_rd v=%b d=%0d op=%0d want 1/2/3",
               snp_valid, snp_dest, snp_op);
    end
    snp_ack = 1'b1;
    @(negedge clk);
    snp_ack = 1'b0;
    #1;
    tests++;
    if ({rsp_valid, rsp_dest} !== {1'b1, 2'd1}) begin
      fails++; $display("FAIL snp_rd_resp v=%b d=%0d want 1/1", rsp_valid, rsp_dest);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order [3];
    int n = 0;
    int both = 0;
    do_reset();
    c1_req_valid = 1; c1_req_op = 3'd3; c1_req_idx = 6'd20;
    c2_req_valid = 1; c2_req_op = 3'd3; c2_req_idx = 6'd21;
    for (int i = 0; i < 30 && n < 3; i++) begin
      #1;
      if (c1_req_ready && c2_req_ready) both++;
      if (c1_req_ready) begin order[n] = 1; n++; end
      else if (c2_req_ready) begin order[n] = 2; n++; end
      @(negedge clk);
    end
    c1_req_valid = 0; c2_req_valid = 0;
    tests++;
    if (n != 3 || both != 0) begin
      fails++; $display("FAIL rr_count grants=%0d both=%0d want 3/0", n, both);
    end else begin
      tests++;
      if (order[0] != 1 || order[1] != 2 || order[2] != 1) begin
        fails++;
        $display("FAIL rr_order got=%0d,%0d,%0d want 1,2,1",
                 order[0], order[1], order[2]);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_noop();
    logic got; int w;
    issue(1, 3'd3, 6'd3, got, w);
    @(negedge clk);
    @(negedge clk);
    issue(1, 3'd0, 6'd3, got, w);
    #1;
    tests++;
    if (!got || ns_op !== 3'd0 || ns_state !== 4'b0001) begin
      fails++;
      $display("FAIL noop_lookup got=%b op=%0d st=%b want 1/0/0001",
               got, ns_op, ns_state);
    end
    @(negedge clk);
    issue(2, 3'd3, 6'd3, got, w);
    #1;
    tests++;
    if (!got || w != 0) begin
      fails++; $display("FAIL noop_idle got=%b waits=%0d want 1/0", got, w);
    end
    tests++;
    if (ns_state !== 4'b0001) begin
      fails++; $display("FAIL noop_entry3 got=%b want 0001", ns_state);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_snoop();
    logic got; int w;
    int seen = 0;
    issue(1, 3'd3, 6'd12, got, w);
    @(negedge clk);
    @(negedge clk);
    issue(2, 3'd4, 6'd12, got, w);
    @(negedge clk); #1;
    tests++;
    if (snp_valid !== 1'b1) begin
      fails++; $display("FAIL rst_snp_pre snp_valid=%b want 1", snp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({snp_valid, rsp_valid, ns_op} !== 5'd0) begin
      fails++;
      $display("FAIL rst_snp_abort snp=%b rsp=%b ns_op=%0d want 0/0/0",
               snp_valid, rsp_valid, ns_op);
    end
    snp_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rsp_valid || snp_valid) seen++;
    end
    snp_ack = 1'b0;
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL rst_snp_noreply cycles=%0d want 0", seen);
    end
    @(negedge clk);
    issue(1, 3'd3, 6'd12, got, w);
    #1;
    tests++;
    if (!got || ns_state !== 4'b0000) begin
      fails++; $display("FAIL rst_snp_entry got=%b st=%b want 1/0000", got, ns_state);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic got; int w;
    int bad = 0;
    int rdy = 0;
    rsp_ready = 1'b0;
    issue(1, 3'd3, 6'd30, got, w);
    @(negedge clk);
    c2_req_valid = 1; c2_req_op = 3'd3; c2_req_idx = 6'd31;
    snp_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if ({rsp_valid, rsp_dest, rsp_op, rsp_idx} !==
          {1'b1, 2'd1, 3'd2, 6'd30}) bad++;
      if (c1_req_ready || c2_req_ready) rdy++;
      @(negedge clk);
    end
    snp_ack = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_stable unstable=%0d want 0", bad);
    end
    tests++;
    if (rdy != 0) begin
      fails++; $display("FAIL bp_ready ready_cycles=%0d want 0", rdy);
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || c2_req_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_last rsp=%b rdy2=%b want 1/0", rsp_valid, c2_req_ready);
    end
    @(negedge clk); #1;
    tests++;
    if (c2_req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept rdy2=%b rsp=%b want 1/0", c2_req_ready, rsp_valid);
    end
    @(negedge clk);
    c2_req_valid = 0;
    #1;
    tests++;
    if (ns_src !== 2'd2 || ns_state !== 4'b0000) begin
      fails++;
      $display("FAIL bp_queued src=%0d st=%b want 2/0000", ns_src, ns_state);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rd_basic();
    test_snoop();
    test_round_robin();
    test_noop();
    test_reset_snoop();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/directory_controller.md
DIRECTORY_CONTROLLER -- requirements
Module: directory_controller

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning directory index width (2**IDX_W entries).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports c1_req_valid/c2_req_valid  input  1  request from cache 1 / cache 2.
REQ-005 SHALL have ports c1_req_ready/c2_req_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports c1_req_op/c2_req_op  input  3  operation (NOOP=0, REPLY=2, RD=3, WR=4, INV=5, UPD=6, RWITM=7).
REQ-007 SHALL have ports c1_req_idx/c2_req_idx  input  IDX_W  directory index.
REQ-008 SHALL have ports ns_state  output  4, ns_op  output  3, ns_src  output  2, ns_dest  output  2: drive to the next-state logic.
REQ-009 SHALL have port ns_next  input  4  next directory entry returned by the next-state logic (combinational).
REQ-010 SHALL have ports snp_valid  output  1, snp_dest  output  2, snp_op  output  3, snp_idx  output  IDX_W, snp_ack  input  1: snoop to the non-requesting cache.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_dest  output  2, rsp_op  output  3, rsp_idx  output  IDX_W, rsp_ready  input  1: reply to the requester.

Function
REQ-012 Directory SHALL hold 2**IDX_W 4-bit entries; bits [1:0] = cache 1 state, [3:2] = cache 2 state; I=0, S=1, M=2.
REQ-013 FSM states SHALL be IDLE, LOOKUP, SNOOP, RESP; one transaction in flight at a time.
REQ-014 IDLE: round-robin arbiter grants one valid port; ready asserted combinationally only for the granted port; handshake latches op, idx, src (1 or 2); next state LOOKUP.
REQ-015 Round-robin: winner of a contested cycle SHALL be the port not served last; after reset cache 1 wins first.
REQ-016 LOOKUP (one cycle): ns_state = entry[idx], ns_op = latched op, ns_src = src, ns_dest = other cache; ns_next captured and written to entry[idx] at end of cycle.
REQ-017 Outside LOOKUP, ns_state/ns_op/ns_src/ns_dest SHALL be 0.
REQ-018 From LOOKUP: op in {NOOP, REPLY, 1} -> IDLE, no write, no snoop, no reply; else if other-cache field of ns_next differs from current -> SNOOP; else -> RESP.
REQ-019 SNOOP: snp_valid=1, snp_dest=other cache, snp_idx=idx, snp_op=INV(5) if other field becomes I, RD(3) if it becomes S; held stable until snp_ack sampled high, then RESP.
REQ-020 RESP: rsp_valid=1, rsp_dest=src, rsp_op=REPLY(2), rsp_idx=idx; held stable until rsp_ready sampled high, then IDLE.
REQ-021 Minimum latency: handshake cycle N, LOOKUP N+1, rsp_valid first high N+2 (no snoop) or N+3 (snoop acked same cycle).
REQ-022 snp_ack outside SNOOP and rsp_ready outside RESP SHALL be ignored.
REQ-023 Both ready outputs SHALL be 0 in every state except IDLE.

Reset
REQ-024 While rst high: FSM -> IDLE, all directory entries -> 0, round-robin pointer -> "cache 2 last", all outputs 0 next cycle.
REQ-025 rst asserted mid-transaction (any state) SHALL abort it without reply or snoop completion; no entry written after the reset edge.

Verification
REQ-026 Reset, c1 RD idx 5 -> ready at N, ns_state=0, ns_src=1 at N+1, rsp_valid at N+2 dest 1 op 2, entry[5]=4'b0001.
REQ-027 entry[9]=4'b0001 (c1 S), c2 RWITM idx 9 -> snp_valid dest 1 op INV; ack after 3 cycles -> rsp to 2; entry[9]=4'b1000.
REQ-028 c1 and c2 both valid in IDLE for 3 transactions -> grant order 1, 2, 1.
REQ-029 c1 NOOP idx 3 -> accepted, no snoop, no reply, entry[3] unchanged, back in IDLE at N+2.
REQ-030 rst pulsed during SNOOP -> snp_valid 0 next cycle, FSM IDLE, all entries 0, pending reply never issued.
REQ-031 rsp_ready held low 5 cycles in RESP -> rsp_* stable, both req_ready stay 0, new requests queued until handshake.
